serial_alu_flags: RTL
=====================

Name: serial_alu_flags

Overview:
Multi-cycle, digit-serial add/subtract/logic unit that sits directly upstream of the comparer stage. It produces the result word and the cout, zero, sign and overflow flags that the comparer consumes to form eql and slt. It trades latency for area by processing DIGIT bits per cycle. Operands and results move through valid/ready handshakes.

Parameters:
WIDTH, 32, operand and result width in bits; must be a multiple of DIGIT.
DIGIT, 1, bits processed per cycle; must be 1, 2, 4 or 8.

Ports:
clk  input  1  rising-edge clock
rst_n  input  1  asynchronous active-low reset
in_valid  input  1  operands and op presented
in_ready  output  1  unit can accept operands
op  input  2  00 add, 01 sub (a - b), 10 and, 11 or
a  input  WIDTH  operand A
b  input  WIDTH  operand B
out_valid  output  1  result and flags valid
out_ready  input  1  downstream (comparer) accepts result
result  output  WIDTH  operation result
cout  output  1  carry out of MSB (sub: 1 = no borrow)
zero  output  1  result == 0
sign  output  1  result[WIDTH-1]
overflow  output  1  signed overflow

Behaviour:
- Reset is asynchronous on rst_n low:
  - state = IDLE; in_ready = 1; out_valid = 0.
  - result, cout, zero, sign and overflow are all 0.
  - The digit counter and operand shift registers are cleared.
  - A reset mid-operation aborts the operation; no output is produced.
- FSM states are IDLE, RUN and DONE.
  - in_ready = 1 only in IDLE.
  - out_valid = 1 only in DONE.
- IDLE -> RUN occurs on an edge with in_valid & in_ready. On that edge:
  - Latch a.
  - Latch b, inverted if op = 01.
  - Latch op.
  - Carry register = 1 for sub, 0 otherwise.
  - Digit counter = 0.
- RUN, each cycle:
  - Compute the low DIGIT bits of the operand shift registers plus carry.
  - Shift the sum digit into result from the MSB side (LSB digit first).
  - Update the carry.
  - Increment the counter.
  - For and/or, the digit is the bitwise op and the carry stays 0.
- RUN -> DONE on the edge that processes digit WIDTH/DIGIT-1.
  - Latency: out_valid rises exactly WIDTH/DIGIT cycles after the accept edge (WIDTH=8, DIGIT=1: 8 cycles).
- Flags registered on entering DONE:
  - cout = final carry out of the MSB (0 for and/or).
  - overflow = carry into MSB XOR carry out of MSB for add/sub; 0 for and/or.
  - zero = NOR of all result bits.
  - sign = result[WIDTH-1].
- DONE holds result and all flags stable while out_ready = 0 (backpressure of arbitrary length).
- DONE -> IDLE on an edge with out_ready = 1. out_valid drops the next cycle, and in_ready rises in the same cycle.
  - No same-cycle turnaround: a new operand is accepted no earlier than one cycle after the output handshake.
- in_valid while in RUN or DONE is ignored. Operand inputs are not sampled outside the accept edge, so changes on a, b or op mid-operation have no effect.
- result and flags outside DONE hold their last value and carry no meaning; the bench must check them only when out_valid = 1.
- Sub implements a + ~b + 1. Extremes need no special-casing:
  - cout = 1 when a >= b unsigned.
  - 0 - 0 gives cout = 1, zero = 1.

Test Plan:
- WIDTH=8, DIGIT=1, sub a=0x05 b=0x05 -> after 8 cycles: out_valid=1, result=0x00, zero=1, cout=1, sign=0, overflow=0.
- Sub a=0x80 b=0x01 -> result=0x7F, cout=1, sign=0, overflow=1, zero=0.
- Add a=0xFF b=0x01 -> result=0x00, cout=1, zero=1, overflow=0. Then sub a=0x03 b=0x05 -> result=0xFE, cout=0, sign=1, overflow=0.
- Hold out_ready=0 for 5 cycles in DONE, toggling a/b/in_valid -> result/flags unchanged, in_ready=0. Release -> out_valid low next cycle, in_ready high.
- Drive rst_n low at cycle 4 of RUN -> out_valid, in_ready and all outputs take their reset values immediately. After release, a fresh sub 0x10-0x20 completes in 8 cycles with result=0xF0, cout=0, sign=1.
- DIGIT=4, WIDTH=32: and 0xF0F0F0F0 & 0xFF00FF00 = 0xF000F000 with cout=0, overflow=0, sign=1, in 8 cycles. Then or 0 | 0 -> zero=1.

Source files
------------

// File: rtl/serial_alu_flags.sv
// Digit-serial add/sub/and/or unit producing result plus cout/zero/sign/overflow
// flags for the downstream comparer; DIGIT bits are processed per cycle.
module serial_alu_flags #(
    parameter int unsigned WIDTH = 32,
    parameter int unsigned DIGIT = 1
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [1:0]       op,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] result,
    output logic             cout,
    output logic             zero,
    output logic             sign,
    output logic             overflow
);

    localparam int unsigned NDIG = WIDTH / DIGIT;
    localparam int unsigned CW   = (NDIG > 1) ? $clog2(NDIG) : 1;

    localparam logic [1:0] OP_ADD = 2'b00;
    localparam logic [1:0] OP_SUB = 2'b01;
    localparam logic [1:0] OP_AND = 2'b10;
    localparam logic [1:0] OP_OR  = 2'b11;

    typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

    state_t           state_q, state_d;
    logic [WIDTH-1:0] sa_q, sa_d, sb_q, sb_d, res_d;
    logic [1:0]       op_q, op_d;
    logic             carry_q, carry_d;
    logic [CW-1:0]    cnt_q, cnt_d;
    logic             cout_d, zero_d, sign_d, ovf_d;

    logic [DIGIT:0]   digit_sum;
    logic [DIGIT-1:0] digit;
    logic             arith;
    logic             last;

    // One digit of the datapath: ripple add on the low operand bits, or a bitwise op
    assign arith     = (op_q == OP_ADD) || (op_q == OP_SUB);
    assign digit_sum = (DIGIT+1)'(sa_q[DIGIT-1:0]) + (DIGIT+1)'(sb_q[DIGIT-1:0])
                     + (DIGIT+1)'(carry_q);
    assign digit     = (op_q == OP_AND) ? (sa_q[DIGIT-1:0] & sb_q[DIGIT-1:0]) :
                       (op_q == OP_OR)  ? (sa_q[DIGIT-1:0] | sb_q[DIGIT-1:0]) :
                                          digit_sum[DIGIT-1:0];
    assign last      = (cnt_q == CW'(NDIG - 1));

    always_comb begin
        state_d = state_q;
        sa_d    = sa_q;
        sb_d    = sb_q;
        op_d    = op_q;
        carry_d = carry_q;
        cnt_d   = cnt_q;
        res_d   = result;
        cout_d  = cout;
        zero_d  = zero;
        sign_d  = sign;
        ovf_d   = overflow;

        unique case (state_q)
            IDLE: begin
                if (in_valid && in_ready) begin
                    sa_d    = a;
                    sb_d    = (op == OP_SUB) ? ~b : b;
                    op_d    = op;
                    carry_d = (op == OP_SUB);
                    cnt_d   = '0;
                    state_d = RUN;
                end
            end
            RUN: begin
                sa_d    = sa_q >> DIGIT;
                sb_d    = sb_q >> DIGIT;
                carry_d = arith & digit_sum[DIGIT];
                res_d   = WIDTH'({digit, result} >> DIGIT);
                cnt_d   = cnt_q + CW'(1);
                if (last) begin
                    state_d = DONE;
                    cout_d  = carry_d;
                    zero_d  = ~|res_d;
                    sign_d  = res_d[WIDTH-1];
                    // Same-sign operands giving a differently signed MSB means signed overflow
                    ovf_d   = arith & (sa_q[DIGIT-1] ~^ sb_q[DIGIT-1])
                                    & (digit[DIGIT-1] ^ sa_q[DIGIT-1]);
                end
            end
            DONE: begin
                if (out_ready) begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= IDLE;
            sa_q      <= '0;
            sb_q      <= '0;
            op_q      <= '0;
            carry_q   <= 1'b0;
            cnt_q     <= '0;
            result    <= '0;
            cout      <= 1'b0;
            zero      <= 1'b0;
            sign      <= 1'b0;
            overflow  <= 1'b0;
            in_ready  <= 1'b1;
            out_valid <= 1'b0;
        end else begin
            state_q   <= state_d;
            sa_q      <= sa_d;
            sb_q      <= sb_d;
            op_q      <= op_d;
            carry_q   <= carry_d;
            cnt_q     <= cnt_d;
            result    <= res_d;
            cout      <= cout_d;
            zero      <= zero_d;
            sign      <= sign_d;
            overflow  <= ovf_d;
            in_ready  <= (state_d == IDLE);
            out_valid <= (state_d == DONE);
        end
    end

endmodule
